// File: rtl/add_one_pkg.sv
// Shared constants and state encoding for the add_one incrementer and its BIST engine.
package add_one_pkg;

  localparam int ADD_ONE_WIDTH = 9;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } bist_state_t;

endpackage

// File: rtl/add_one_bist.sv
// Hardware stimulus/checker for add_one: walks x through an arithmetic sequence,
// compares y against x+1 after a settle delay and keeps first-failure and error-count results.
module add_one_bist
  import add_one_pkg::*;
#(
  parameter int WIDTH  = ADD_ONE_WIDTH,
  parameter int STEP   = 17,
  parameter int COUNT  = 256,
  parameter int SETTLE = 1,
  parameter int ERRW   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERRW-1:0]  err_count,
  output logic [WIDTH-1:0] err_x,
  output logic [WIDTH-1:0] err_y
);

  localparam int IDXW = $clog2(COUNT + 1);
  localparam int SETW = $clog2(SETTLE + 1);
  localparam logic [IDXW-1:0]  LAST_IDX    = IDXW'(COUNT - 1);
  localparam logic [SETW-1:0]  SETTLE_INIT = SETW'(SETTLE);
  localparam logic [SETW-1:0]  SETTLE_ONE  = SETW'(1);
  localparam logic [WIDTH-1:0] STEP_W      = WIDTH'(STEP);
  localparam logic [ERRW-1:0]  ERR_MAX     = '1;

  bist_state_t      state_q;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] errX_q;
  logic [WIDTH-1:0] errY_q;
  logic [ERRW-1:0]  errCount_q;
  logic [IDXW-1:0]  idx_q;
  logic [SETW-1:0]  settle_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH-1:0] expY_d;
  logic             mismatch_d;
  logic [ERRW-1:0]  errCount_d;

  // Expected response wraps naturally in WIDTH bits; the counter sticks at its maximum.
  assign expY_d     = x_q + WIDTH'(1);
  assign mismatch_d = (y != expY_d);
  assign errCount_d = (errCount_q == ERR_MAX) ? errCount_q : errCount_q + ERRW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      x_q        <= '0;
      errX_q     <= '0;
      errY_q     <= '0;
      errCount_q <= '0;
      idx_q      <= '0;
      settle_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q    <= RUN;
            x_q        <= '0;
            idx_q      <= '0;
            settle_q   <= SETTLE_INIT;
            errCount_q <= '0;
            errX_q     <= '0;
            errY_q     <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          if (settle_q != SETTLE_ONE) begin
            settle_q <= settle_q - SETW'(1);
          end else begin
            // A zero count means no mismatch yet this run, since it never wraps back.
            if (mismatch_d) begin
              errCount_q <= errCount_d;
              if (errCount_q == '0) begin
                errX_q <= x_q;
                errY_q <= y;
              end
            end
            if (idx_q == LAST_IDX) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              x_q      <= x_q + STEP_W;
              idx_q    <= idx_q + IDXW'(1);
              settle_q <= SETTLE_INIT;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign x         = x_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = done_q && (errCount_q == '0);
  assign err_count = errCount_q;
  assign err_x     = errX_q;
  assign err_y     = errY_q;

endmodule

// File: doc/add_one_bist.md
# add_one_bist

Synthesisable self-checking stimulus engine for the 9-bit `add_one` incrementer. It is the driving and checking end of the `x`/`y` interface, moved from bench to hardware. On `start` it walks `x` through an arithmetic sequence, waits a programmable settle time per vector, and compares `y` against `x+1` modulo 2^WIDTH. It records the first mismatch and a saturating error count, and reports done/pass for on-chip or lab bring-up.

## Interface
Reset is asynchronous and active-low. The block has a single clock.

Parameters:
- `WIDTH`, 9: data width of `x` and `y`.
- `STEP`, 17: increment applied to `x` between vectors, modulo 2^WIDTH.
- `COUNT`, 256: number of vectors per run; must be ≥1.
- `SETTLE`, 1: cycles between an `x` update and the sample of `y`; must be ≥1.
- `ERRW`, 8: width of the saturating error counter.

Ports:
- `clk` in 1: clock, rising-edge active.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: single-cycle run request.
- `x` out WIDTH: registered stimulus to the DUT.
- `y` in WIDTH: DUT response.
- `busy` out 1: high while a run is in progress.
- `done` out 1: high from run completion until the next accepted `start`.
- `pass` out 1: `done && err_count==0`.
- `err_count` out ERRW: mismatches in the current/last run; saturates at 2^ERRW−1.
- `err_x` out WIDTH: `x` of the first mismatch.
- `err_y` out WIDTH: `y` of the first mismatch.

## Operation
- States:
  - IDLE: after reset.
  - RUN.
  - DONE.
- Reset (any state, mid-run included): state=IDLE. `x`, `err_x`, `err_y`, `err_count`, vector index and settle counter all become 0. `busy`, `done` and `pass` become 0.
- IDLE/DONE + `start`:
  - `x`←0, index←0, settle←SETTLE.
  - Clear `err_count`, `err_x`, `err_y` and `done`.
  - Go to RUN; `busy`=1.
- RUN, settle>1: settle decrements; `x` holds.
- RUN, settle==1: sample edge.
  - Compare `y` to `(x+1) mod 2^WIDTH`, with WIDTH-bit wrap (`x`=2^WIDTH−1 expects 0).
  - On mismatch: `err_count`+1, saturating. If this is the first mismatch of the run, latch `err_x`←`x` and `err_y`←`y`.
  - If index==COUNT−1: go to DONE on this edge, with `done`=1 and `busy`=0. `x` holds its last value.
  - Otherwise: `x`←`(x+STEP) mod 2^WIDTH`, index+1, settle←SETTLE.
- `start` in RUN is ignored; the run is not restarted.
- `start` in DONE restarts the run; results are cleared on that edge.

## Timing
- `start` is sampled at edge E0. `x`=0 is visible after E0.
- Sample of vector k occurs at edge E0+(k+1)·SETTLE. `x` changes on that same edge.
- `done` rises after edge E0+COUNT·SETTLE. Total run length is COUNT·SETTLE cycles.
- `y` is sampled on the clock edge only, with no internal registering of `y`. The DUT path must settle within SETTLE cycles.
- All outputs are registered. `pass` is registered, or derived from registered `done` and `err_count` only.
- `err_count`, `err_x` and `err_y` are valid (final) when `done`=1; they may be read mid-run.

## Structure
- Shared package `add_one_pkg`:
  - `ADD_ONE_WIDTH`=9.
  - `bist_state_t` enum {IDLE, RUN, DONE}.
- Single module with no sub-module; the settle counter and index counter are inline.
- Index counter width is `$clog2(COUNT+1)`.
- Settle counter width is `$clog2(SETTLE+1)`.

## Test plan
- Correct `add_one`, defaults, pulse `start`:
  - `done` after 256 cycles, `pass`=1, `err_count`=0.
  - `x` visits 0,17,34,…; last value 239.
- Faulty DUT `y=x`:
  - `err_x`=0, `err_y`=0.
  - `err_count` saturates at 255 (256 mismatches); `pass`=0.
- Faulty DUT `y=x+1` except `y=0` at `x`=239:
  - `err_count`=1, `err_x`=239, `err_y`=0 (last vector caught).
- SETTLE=3, COUNT=4, correct DUT:
  - `x` steps 0,17,34,51, each held 3 cycles.
  - `done` rises 12 cycles after `start`.
- `start` pulsed mid-run:
  - No restart; the sequence continues.
  - Then `start` in DONE clears `err_*` and reruns.
- `rst_n` low mid-run (asynchronous, between edges):
  - All outputs 0 immediately; state IDLE.
  - After release, a new `start` completes normally.
